// File: rtl/rgb2y_pipe_if.sv
// Pixel-stream bundle for rgb2y_pipe: capture-side inputs plus the luma, sync, event and position outputs.
// The slave modport is the converter side; the master modport is the source/sink side.
interface rgb2y_pipe_if #(
  parameter int COLORDEPTH = 8,
  parameter int CNT_W      = 12
);
  logic [3*COLORDEPTH-1:0] rgb_i;
  logic                    dv_i;
  logic                    hs_i;
  logic                    vs_i;
  logic                    coef_sel_i;

  logic [COLORDEPTH-1:0]   y_o;
  logic                    dv_o;
  logic                    hs_o;
  logic                    vs_o;
  logic                    line_end_o;
  logic                    frame_start_o;
  logic [CNT_W-1:0]        x_o;
  logic [CNT_W-1:0]        line_o;

  modport slave (
    input  rgb_i, dv_i, hs_i, vs_i, coef_sel_i,
    output y_o, dv_o, hs_o, vs_o, line_end_o, frame_start_o, x_o, line_o
  );

  modport master (
    output rgb_i, dv_i, hs_i, vs_i, coef_sel_i,
    input  y_o, dv_o, hs_o, vs_o, line_end_o, frame_start_o, x_o, line_o
  );
endinterface

// File: rtl/rgb2y_pipe.sv
// RGB-to-luma converter, 3-stage pipeline: weighted products, rounded sum, saturated luma.
// Sync, line-end/frame-start pulses and pixel/line counters are aligned to the luma output.
module rgb2y_pipe #(
  parameter int COLORDEPTH = 8,
  parameter int COEF_W     = 8,
  parameter int KR0        = 77,
  parameter int KG0        = 150,
  parameter int KB0        = 29,
  parameter int KR1        = 54,
  parameter int KG1        = 183,
  parameter int KB1        = 19,
  parameter int ROUND      = 1,
  parameter int CNT_W      = 12
) (
  input  logic           clk,
  input  logic           rst,
  rgb2y_pipe_if.slave    bus
);

  localparam int D  = COLORDEPTH;
  localparam int PW = D + COEF_W + 1;
  localparam int SW = D + COEF_W + 3;

  localparam logic [COEF_W:0] KR0_C = (COEF_W+1)'(KR0);
  localparam logic [COEF_W:0] KG0_C = (COEF_W+1)'(KG0);
  localparam logic [COEF_W:0] KB0_C = (COEF_W+1)'(KB0);
  localparam logic [COEF_W:0] KR1_C = (COEF_W+1)'(KR1);
  localparam logic [COEF_W:0] KG1_C = (COEF_W+1)'(KG1);
  localparam logic [COEF_W:0] KB1_C = (COEF_W+1)'(KB1);

  localparam logic [SW-1:0]    HALF = (ROUND != 0) ? (SW'(1) << (COEF_W - 1)) : '0;
  localparam logic [SW-1:0]    YMAX = SW'((1 << D) - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  function automatic logic [SW-1:0] round_bias(input logic [SW-1:0] s);
    return s + HALF;
  endfunction

  function automatic logic [D-1:0] sat_y(input logic [SW-1:0] s);
    logic [SW-1:0] q;
    q = s >> COEF_W;
    if (q > YMAX) return '1;
    return q[D-1:0];
  endfunction

  logic [D-1:0]     r_in, g_in, b_in;
  logic             sel_q, vs_rise, sel_eff;
  logic [COEF_W:0]  kr, kg, kb;

  logic [PW-1:0]    prod_r_p1, prod_g_p1, prod_b_p1;
  logic             dv_p1, hs_p1, vs_p1;
  logic [SW-1:0]    sum_p2;
  logic             dv_p2, hs_p2, vs_p2;
  logic [D-1:0]     y_p3;
  logic             dv_p3, hs_p3, vs_p3;
  logic             le_p3, fs_p3;
  logic             le_next, fs_next;
  logic [CNT_W-1:0] x_q, line_q;

  assign r_in = bus.dv_i ? bus.rgb_i[3*D-1:2*D] : '0;
  assign g_in = bus.dv_i ? bus.rgb_i[2*D-1:D]   : '0;
  assign b_in = bus.dv_i ? bus.rgb_i[D-1:0]     : '0;

  // vs_p1 holds the previous vs_i, so a rising edge lets the current pixel use the new set
  assign vs_rise = bus.vs_i & ~vs_p1;
  assign sel_eff = vs_rise ? bus.coef_sel_i : sel_q;

  always_comb begin
    kr = sel_eff ? KR1_C : KR0_C;
    kg = sel_eff ? KG1_C : KG0_C;
    kb = sel_eff ? KB1_C : KB0_C;
  end

  // Stage 1: weighted products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r_p1 <= '0;
      prod_g_p1 <= '0;
      prod_b_p1 <= '0;
      dv_p1     <= 1'b0;
      hs_p1     <= 1'b0;
      vs_p1     <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      prod_r_p1 <= PW'(kr) * PW'(r_in);
      prod_g_p1 <= PW'(kg) * PW'(g_in);
      prod_b_p1 <= PW'(kb) * PW'(b_in);
      dv_p1     <= bus.dv_i;
      hs_p1     <= bus.hs_i;
      vs_p1     <= bus.vs_i;
      sel_q     <= sel_eff;
    end
  end

  // Stage 2: rounded sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_p2 <= '0;
      dv_p2  <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
    end else begin
      sum_p2 <= round_bias(SW'(prod_r_p1) + SW'(prod_g_p1) + SW'(prod_b_p1));
      dv_p2  <= dv_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  // Stage 3: saturated luma; events look one stage ahead so their pulses land on the dv_o/vs_o transitions
  assign le_next = dv_p3 & ~dv_p2;
  assign fs_next = vs_p2 & ~vs_p3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_p3  <= '0;
      dv_p3 <= 1'b0;
      hs_p3 <= 1'b0;
      vs_p3 <= 1'b0;
      le_p3 <= 1'b0;
      fs_p3 <= 1'b0;
    end else begin
      y_p3  <= sat_y(sum_p2);
      dv_p3 <= dv_p2;
      hs_p3 <= hs_p2;
      vs_p3 <= vs_p2;
      le_p3 <= le_next;
      fs_p3 <= fs_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      line_q <= '0;
    end else begin
      if (le_next)                    x_q <= '0;
      else if (dv_p3 && x_q != CMAX)  x_q <= x_q + CNT_W'(1);

      if (fs_next)                      line_q <= '0;
      else if (le_p3 && line_q != CMAX) line_q <= line_q + CNT_W'(1);
    end
  end

  assign bus.y_o           = y_p3;
  assign bus.dv_o          = dv_p3;
  assign bus.hs_o          = hs_p3;
  assign bus.vs_o          = vs_p3;
  assign bus.line_end_o    = le_p3;
  assign bus.frame_start_o = fs_p3;
  assign bus.x_o           = x_q;
  assign bus.line_o        = line_q;

endmodule

// File: tb/tb_rgb2y_pipe.sv
// Directed bench for rgb2y_pipe: coefficients, frame-latched select, line/frame events, counters,
// asynchronous reset and luma saturation with oversized coefficients.
module tb_rgb2y_pipe;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  rgb2y_pipe_if #(.COLORDEPTH(8), .CNT_W(12)) mif ();
  rgb2y_pipe_if #(.COLORDEPTH(8), .CNT_W(12)) sif ();

  rgb2y_pipe u_dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  rgb2y_pipe #(.KR0(255), .KG0(255), .KB0(255)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] rgb, input logic dv, input logic hs,
                       input logic vs, input logic sel);
    mif.rgb_i      = rgb;
    mif.dv_i       = dv;
    mif.hs_i       = hs;
    mif.vs_i       = vs;
    mif.coef_sel_i = sel;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    sif.rgb_i = 24'h0; sif.dv_i = 1'b0; sif.hs_i = 1'b0; sif.vs_i = 1'b0; sif.coef_sel_i = 1'b0;
    tick(); tick();

    chk("rst_y",  32'(mif.y_o), 0);
    chk("rst_dv", 32'(mif.dv_o), 0);
    chk("rst_hs", 32'(mif.hs_o), 0);
    chk("rst_vs", 32'(mif.vs_o), 0);
    chk("rst_le", 32'(mif.line_end_o), 0);
    chk("rst_fs", 32'(mif.frame_start_o), 0);
    chk("rst_x",  32'(mif.x_o), 0);
    chk("rst_line", 32'(mif.line_o), 0);

    rst = 1'b1;
    tick();

    // Frame start: vs_i high for two cycles
    drive(24'h0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    tick();
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("fs_pulse", 32'(mif.frame_start_o), 1);
    chk("fs_vs_o",  32'(mif.vs_o), 1);
    chk("fs_line",  32'(mif.line_o), 0);
    tick();
    chk("fs_once",  32'(mif.frame_start_o), 0);
    tick(); tick();

    // Four-pixel line, set 0: grey, red, green, white
    drive(24'h808080, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(24'h00FF00, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("grey_y",  32'(mif.y_o), 128);
    chk("grey_dv", 32'(mif.dv_o), 1);
    chk("x0",      32'(mif.x_o), 0);
    drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("red0_y",  32'(mif.y_o), 77);
    chk("x1",      32'(mif.x_o), 1);
    drive(24'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("green0_y", 32'(mif.y_o), 149);
    chk("x2",       32'(mif.x_o), 2);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("white0_y", 32'(mif.y_o), 255);
    chk("x3",       32'(mif.x_o), 3);
    chk("le_early", 32'(mif.line_end_o), 0);
    tick();
    chk("le_pulse", 32'(mif.line_end_o), 1);
    chk("le_x",     32'(mif.x_o), 0);
    chk("le_dv",    32'(mif.dv_o), 0);
    chk("idle_y",   32'(mif.y_o), 0);
    chk("hs_delay", 32'(mif.hs_o), 1);
    chk("le_line",  32'(mif.line_o), 0);
    tick();
    chk("line_inc", 32'(mif.line_o), 1);
    chk("le_once",  32'(mif.line_end_o), 0);
    chk("hs_once",  32'(mif.hs_o), 0);

    // Two one-pixel lines separated by a single idle cycle
    drive(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p1a_dv", 32'(mif.dv_o), 1);
    chk("p1a_y",  32'(mif.y_o), 77);
    chk("p1a_x",  32'(mif.x_o), 0);
    tick();
    chk("p1a_le", 32'(mif.line_end_o), 1);
    chk("p1a_gap", 32'(mif.dv_o), 0);
    tick();
    chk("p1b_dv", 32'(mif.dv_o), 1);
    chk("p1b_le0", 32'(mif.line_end_o), 0);
    chk("p1b_line", 32'(mif.line_o), 2);
    chk("p1b_x",  32'(mif.x_o), 0);
    tick();
    chk("p1b_le", 32'(mif.line_end_o), 1);
    tick();
    chk("p1b_line_inc", 32'(mif.line_o), 3);
    tick();

    // Mid-frame select request must not take effect
    drive(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    tick();
    chk("sel_mid_y", 32'(mif.y_o), 77);
    tick(); tick(); tick();

    // New frame latches set 1 in the edge cycle; later toggles hold
    drive(24'hFF0000, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    drive(24'hFF0000, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("red1_y",   32'(mif.y_o), 54);
    chk("f2_fs",    32'(mif.frame_start_o), 1);
    chk("f2_line",  32'(mif.line_o), 0);
    tick();
    chk("red1_hold_y", 32'(mif.y_o), 54);
    tick();
    chk("white1_y", 32'(mif.y_o), 255);
    chk("f2_x2",    32'(mif.x_o), 2);
    tick(); tick();
    chk("f2_line1", 32'(mif.line_o), 1);
    tick();

    // Asynchronous reset mid-line
    drive(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    tick(); tick();
    chk("pre_rst_dv", 32'(mif.dv_o), 1);
    chk("pre_rst_y",  32'(mif.y_o), 54);
    #2 rst = 1'b0;
    #1;
    chk("arst_y",    32'(mif.y_o), 0);
    chk("arst_dv",   32'(mif.dv_o), 0);
    chk("arst_line", 32'(mif.line_o), 0);
    chk("arst_x",    32'(mif.x_o), 0);
    tick();
    rst = 1'b1;
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst_le_a", 32'(mif.line_end_o), 0);
    tick();
    chk("post_rst_le_b", 32'(mif.line_end_o), 0);
    chk("post_rst_dv",   32'(mif.dv_o), 0);
    drive(24'hFF0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    tick();
    chk("post_rst_set0_y", 32'(mif.y_o), 77);
    chk("post_rst_dv1",    32'(mif.dv_o), 1);
    tick();

    // Oversized coefficients: white must clamp, not wrap
    sif.rgb_i = 24'hFFFFFF; sif.dv_i = 1'b1; tick();
    sif.rgb_i = 24'h0;      sif.dv_i = 1'b0; tick();
    tick();
    chk("sat_y",  32'(sif.y_o), 255);
    chk("sat_dv", 32'(sif.dv_o), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
